param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ram.sv | 27 ++
 rtl/param_sync_fifo.sv | 117 +++++++++++
 tb/tb_param_sync_fifo.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and pointer helper for the synchronous FIFO family.
// The wrap helper compares against the last slot, so it works for any depth.
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH = 50;

    // Advance a ring pointer, wrapping from depth-1 back to 0.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: synchronous write port, asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH = FIFO_DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, error pulses
// and a selectable registered or first-word-fall-through read path.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_DEF_WIDTH,
    parameter int DEPTH     = FIFO_DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "param_sync_fifo: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "param_sync_fifo: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $fatal(1, "param_sync_fifo: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "param_sync_fifo: AE_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $fatal(1, "param_sync_fifo: FWFT must be 0 or 1");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] head;
    logic             wr_acc;
    logic             rd_acc;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // A write that collides with a pop at full is dropped without raising overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= PW'(ptr_inc(32'(wr_ptr), $unsigned(DEPTH)));
            end
            if (rd_acc) begin
                rd_ptr <= PW'(ptr_inc(32'(rd_ptr), $unsigned(DEPTH)));
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow  <= wr_en && full && !rd_en;
            underflow <= rd_en && empty;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Gating on empty keeps stale memory from ever reaching the output.
        assign rd_data  = empty ? '0 : head;
        assign rd_valid = !empty;
    end else begin : g_registered
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_acc;
                if (rd_acc) begin
                    rd_data <= head;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_param_sync_fifo;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] count;

    logic       f_wr_en = 1'b0;
    logic       f_rd_en = 1'b0;
    logic [7:0] f_wr_data = 8'h00;
    logic [7:0] f_rd_data;
    logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [2:0] f_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: queue contents plus the expected registered outputs.
    logic [7:0] q[$];
    logic [7:0] exp_rd_data = 8'h00;
    logic       exp_rd_valid = 1'b0;
    logic       exp_ovf = 1'b0;
    logic       exp_udf = 1'b0;

    always #5 clk = ~clk;

    param_sync_fifo #(
        .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    param_sync_fifo #(
        .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
    ) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    // Drive one cycle on the registered-read instance and advance the model.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rs);
        logic wacc;
        logic racc;
        rst     = rs;
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        wacc = w && (q.size() < D);
        racc = r && (q.size() > 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (rs) begin
            q.delete();
            exp_rd_data  = 8'h00;
            exp_rd_valid = 1'b0;
            exp_ovf      = 1'b0;
            exp_udf      = 1'b0;
        end else begin
            exp_ovf      = w && (q.size() == D) && !r;
            exp_udf      = r && (q.size() == 0);
            exp_rd_valid = racc;
            if (racc) exp_rd_data = q.pop_front();
            if (wacc) q.push_back(d);
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if ({count, empty, full, almost_empty, almost_full} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b want %b",
                     {count, empty, full, almost_empty, almost_full}, {3'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        checks++;
        if ({rd_data, rd_valid, overflow, underflow} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want %h", {rd_data, rd_valid, overflow, underflow}, 11'h000);
        end
        checks++;
        if ({f_empty, f_rd_valid, f_count} !== {1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("[TB] FAIL reset_fwft got %b want %b", {f_empty, f_rd_valid, f_count}, 5'b10000);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
        checks++;
        if ({full, count} !== {1'b1, 3'd5}) begin
            errors++;
            $display("[TB] FAIL fill_full got full=%b count=%0d want full=1 count=5", full, count);
        end
        step(1'b1, 1'b0, 8'h16, 1'b0);
        checks++;
        if ({overflow, count} !== {1'b1, 3'd5}) begin
            errors++;
            $display("[TB] FAIL fill_overflow got ovf=%b count=%0d want ovf=1 count=5", overflow, count);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_overflow_once got %b want 0", overflow);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if ({rd_valid, rd_data} !== {1'b1, 8'(8'h11 + i)}) begin
                errors++;
                $display("[TB] FAIL drain_data[%0d] got valid=%b data=%h want valid=1 data=%h",
                         i, rd_valid, rd_data, 8'(8'h11 + i));
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_empty got %b want 1", empty);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] want;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 8'(8'h50 + i), 1'b0);
            want = (i < 3) ? 8'(8'h40 + i) : 8'(8'h50 + i - 3);
            checks++;
            if ({count, rd_valid, rd_data} !== {3'd3, 1'b1, want}) begin
                errors++;
                $display("[TB] FAIL wrap_pair[%0d] got count=%0d valid=%b data=%h want count=3 valid=1 data=%h",
                         i, count, rd_valid, rd_data, want);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if (rd_data !== 8'(8'h59 + i)) begin
                errors++;
                $display("[TB] FAIL wrap_tail[%0d] got %h want %h", i, rd_data, 8'(8'h59 + i));
            end
        end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        step(1'b1, 1'b1, 8'h70, 1'b0);
        checks++;
        if ({count, overflow, rd_data} !== {3'd4, 1'b0, 8'h60}) begin
            errors++;
            $display("[TB] FAIL full_both got count=%0d ovf=%b data=%h want count=4 ovf=0 data=60",
                     count, overflow, rd_data);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if ({empty, rd_data} !== {1'b1, 8'h64}) begin
            errors++;
            $display("[TB] FAIL full_both_drain got empty=%b data=%h want empty=1 data=64", empty, rd_data);
        end
        step(1'b1, 1'b1, 8'h80, 1'b0);
        checks++;
        if ({count, underflow, rd_valid} !== {3'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL empty_both got count=%0d udf=%b valid=%b want count=1 udf=1 valid=0",
                     count, underflow, rd_valid);
        end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if ({underflow, rd_valid, rd_data} !== {1'b0, 1'b1, 8'h80}) begin
            errors++;
            $display("[TB] FAIL empty_both_read got udf=%b valid=%b data=%h want udf=0 valid=1 data=80",
                     underflow, rd_valid, rd_data);
        end
    endtask

    task automatic test_thresholds();
        for (int c = 0; c <= 10; c++) begin
            int lvl;
            lvl = (c <= 5) ? c : 10 - c;
            if (c > 0 && c <= 5) step(1'b1, 1'b0, 8'(c), 1'b0);
            if (c > 5) step(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if ({count, almost_empty, almost_full} !== {3'(lvl), lvl <= 1, lvl >= 4}) begin
                errors++;
                $display("[TB] FAIL thresh[%0d] got count=%0d ae=%b af=%b want count=%0d ae=%b af=%b",
                         c, count, almost_empty, almost_full, lvl, lvl <= 1, lvl >= 4);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
        step(1'b1, 1'b0, 8'hEE, 1'b1);
        checks++;
        if ({count, empty, rd_valid} !== {3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mid_reset got count=%0d empty=%b valid=%b want count=0 empty=1 valid=0",
                     count, empty, rd_valid);
        end
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if ({rd_valid, rd_data, count} !== {1'b1, 8'hA5, 3'd0}) begin
            errors++;
            $display("[TB] FAIL mid_reset_read got valid=%b data=%h count=%0d want valid=1 data=a5 count=0",
                     rd_valid, rd_data, count);
        end
    endtask

    task automatic test_random();
        logic [17:0] got;
        logic [17:0] want;
        for (int i = 0; i < 400; i++) begin
            logic w, r, rs;
            w  = (i < 200) ? ($urandom_range(0, 99) < 65) : ($urandom_range(0, 99) < 35);
            r  = (i < 200) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 65);
            rs = ($urandom_range(0, 99) == 0);
            step(w, r, 8'($urandom), rs);
            got  = {count, full, empty, almost_full, almost_empty, rd_valid, rd_data, overflow, underflow};
            want = {3'(q.size()), q.size() == D, q.size() == 0, q.size() >= AF, q.size() <= AE,
                    exp_rd_valid, exp_rd_data, exp_ovf, exp_udf};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL random[%0d] got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_fwft();
        f_wr_data = 8'h3C;
        f_wr_en   = 1'b1;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0;
        checks++;
        if ({f_rd_valid, f_rd_data} !== {1'b1, 8'h3C}) begin
            errors++;
            $display("[TB] FAIL fwft_show got valid=%b data=%h want valid=1 data=3c", f_rd_valid, f_rd_data);
        end
        f_rd_en = 1'b1;
        @(posedge clk);
        #1;
        f_rd_en = 1'b0;
        checks++;
        if ({f_rd_valid, f_empty} !== {1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL fwft_pop got valid=%b empty=%b want valid=0 empty=1", f_rd_valid, f_empty);
        end
        for (int i = 0; i < 3; i++) begin
            f_wr_data = 8'(8'hC0 + i);
            f_wr_en   = 1'b1;
            @(posedge clk);
            #1;
        end
        f_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({f_rd_valid, f_rd_data} !== {1'b1, 8'(8'hC0 + i)}) begin
                errors++;
                $display("[TB] FAIL fwft_head[%0d] got valid=%b data=%h want valid=1 data=%h",
                         i, f_rd_valid, f_rd_data, 8'(8'hC0 + i));
            end
            f_rd_en = 1'b1;
            @(posedge clk);
            #1;
            f_rd_en = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_boundary();
        test_thresholds();
        test_mid_reset();
        test_fwft();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
